// File: rtl/qsm_dim_master_pkg.sv
// Shared types and helpers for the QSM DIM readout master (qsm_dim_master).
package qsm_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_PULSE,
        ST_TRIG,
        ST_SHIFT,
        ST_STORE,
        ST_FB_CHK,
        ST_DELAY
    } qsm_state_e;

    localparam int FRAME_BITS = 17;
    localparam int MAX_DEV    = 8;
    localparam int TICK_W     = 20;

    function automatic logic [6:0] pack_addr(input logic [2:0] dev, input logic [3:0] regn);
        return {dev, regn};
    endfunction

    // The SRAM window only holds MAX_DEV devices, so larger requests are clamped.
    function automatic logic [3:0] eff_max(input logic [3:0] max_no);
        return (max_no > 4'(MAX_DEV)) ? 4'(MAX_DEV) : max_no;
    endfunction
endpackage

// File: rtl/qsm_dim_master_if.sv
// Readout SRAM write port driven by qsm_dim_master.
interface qsm_dim_master_if;
    logic        mem_we_o;
    logic [6:0]  mem_addr_o;
    logic [15:0] mem_data_o;

    modport master (output mem_we_o, mem_addr_o, mem_data_o);
    modport slave  (input  mem_we_o, mem_addr_o, mem_data_o);
endinterface

// File: rtl/qsm_dim_master_tick_gen.sv
// qsm_tick_gen: microsecond prescaler feeding a down-counter; o_last marks the
// final cycle of an i_us x US_TICKS window started by i_load.
module qsm_tick_gen
    import qsm_pkg::*;
#(
    parameter int US_TICKS = 100
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_load,
    input  logic [TICK_W-1:0] i_us,
    output logic              o_last
);
    localparam int PW = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
    localparam logic [PW-1:0] PRE_END = PW'(US_TICKS - 1);

    logic [PW-1:0]     r_pre;
    logic [TICK_W-1:0] r_cnt;
    logic              r_run;

    assign o_last = r_run && (r_cnt == TICK_W'(1)) && (r_pre == PRE_END);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_pre <= '0;
            r_cnt <= i_us;
            r_run <= (i_us != '0);
        end else if (r_run) begin
            if (r_pre == PRE_END) begin
                r_pre <= '0;
                r_cnt <= r_cnt - TICK_W'(1);
                if (r_cnt == TICK_W'(1)) r_run <= 1'b0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end
endmodule

// File: rtl/qsm_dim_master.sv
// QSPI master for DIM readout: trigger, shift 17-bit frames per device, store words.
// Optional feedback-line check enabled by defining QSM_FB_CHECK_EN.
module qsm_dim_master
    import qsm_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int US_TICKS = 100,
    parameter int RESET_US = 1000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ctrl_reset_i,
    input  logic             ctrl_trig_i,
    input  logic [3:0]       last_reg_adr_i,
    input  logic [3:0]       max_dim_no_i,
    input  logic [9:0]       read_delay_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_many_o,
    output logic             err_fb_o,
    output logic [3:0]       dim_count_o,
    output logic             dim_reset_o,
    output logic             dim_trig_o,
    output logic             dim_clk_o,
    input  logic             dim_data_i,
    input  logic             dim_fb_i,
    qsm_dim_master_if.master mem
);
    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int PH_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_END  = PH_W'(BIT_CYC - 1);

    qsm_state_e        r_state;
    logic [PH_W-1:0]   r_phase;
    logic [4:0]        r_bit;
    logic              r_gap;
    logic              r_sample;
    logic [15:0]       r_sr;
    logic [3:0]        r_dev, r_reg, r_last_reg, r_max;
    logic [9:0]        r_delay;
    logic              r_busy, r_done, r_err_many, r_err_fb;
    logic [3:0]        r_count;
    logic              r_dim_rst, r_dim_trig, r_dim_clk;
    logic              r_we;
    logic [6:0]        r_addr;
    logic [15:0]       r_data;

    logic              w_last_reg;
    logic              w_tk_load;
    logic [TICK_W-1:0] w_tk_us;
    logic              w_tk_last;

    assign w_last_reg = (r_reg == r_last_reg);
    assign w_tk_load  = ctrl_reset_i ||
                        ((r_state == ST_FB_CHK) && !w_last_reg && (r_delay != '0));
    assign w_tk_us    = ctrl_reset_i ? TICK_W'(RESET_US) : TICK_W'(r_delay);

    qsm_tick_gen #(.US_TICKS(US_TICKS)) u_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_load  (w_tk_load),
        .i_us    (w_tk_us),
        .o_last  (w_tk_last)
    );

`ifndef QSM_FB_CHECK_EN
    logic w_unused_fb;
    assign w_unused_fb = dim_fb_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_bit      <= '0;
            r_gap      <= 1'b0;
            r_sample   <= 1'b0;
            r_sr       <= '0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_last_reg <= '0;
            r_max      <= '0;
            r_delay    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_many <= 1'b0;
            r_err_fb   <= 1'b0;
            r_count    <= '0;
            r_dim_rst  <= 1'b0;
            r_dim_trig <= 1'b0;
            r_dim_clk  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_we <= 1'b0;
            if (ctrl_reset_i) begin
                r_state    <= ST_RST_PULSE;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_err_many <= 1'b0;
                r_err_fb   <= 1'b0;
                r_count    <= '0;
                r_dim_rst  <= 1'b1;
                r_dim_trig <= 1'b0;
                r_dim_clk  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ctrl_trig_i) begin
                            r_last_reg <= last_reg_adr_i;
                            r_max      <= eff_max(max_dim_no_i);
                            r_delay    <= read_delay_i;
                            r_done     <= 1'b0;
                            r_err_many <= 1'b0;
                            r_err_fb   <= 1'b0;
                            r_reg      <= '0;
                            r_dev      <= '0;
                            r_busy     <= 1'b1;
                            r_dim_trig <= 1'b1;
                            r_phase    <= '0;
                            r_state    <= ST_TRIG;
                        end
                    end
                    ST_RST_PULSE: begin
                        if (w_tk_last) begin
                            r_dim_rst <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                    ST_TRIG: begin
                        if (r_phase == PH_END) begin
                            r_dim_trig <= 1'b0;
                            r_phase    <= '0;
                            r_bit      <= '0;
                            r_gap      <= 1'b1;
                            r_state    <= ST_SHIFT;
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        // One idle bit period after the trigger lets the chain load its words.
                        if (r_phase == PH_RISE && !r_gap) begin
                            r_dim_clk <= 1'b1;
                            r_sample  <= dim_data_i;
                            if (r_bit != '0) r_sr <= {r_sr[14:0], dim_data_i};
                        end
                        if (r_phase == PH_END) begin
                            r_phase   <= '0;
                            r_dim_clk <= 1'b0;
                            r_gap     <= 1'b0;
                            if (!r_gap) begin
                                if (r_bit == '0) begin
                                    if (!r_sample) begin
                                        r_state <= ST_FB_CHK;
                                    end else if (r_dev == r_max) begin
                                        r_err_many <= 1'b1;
                                        r_state    <= ST_FB_CHK;
                                    end else begin
                                        r_bit <= 5'd1;
                                    end
                                end else if (r_bit == 5'(FRAME_BITS - 1)) begin
                                    r_we    <= 1'b1;
                                    r_addr  <= pack_addr(r_dev[2:0], r_reg);
                                    r_data  <= r_sr;
                                    r_state <= ST_STORE;
                                end else begin
                                    r_bit <= r_bit + 5'd1;
                                end
                            end
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
                    ST_STORE: begin
                        r_dev   <= r_dev + 4'd1;
                        r_bit   <= '0;
                        r_phase <= '0;
                        r_state <= ST_SHIFT;
                    end
                    ST_FB_CHK: begin
                        r_count <= r_dev;
`ifdef QSM_FB_CHECK_EN
                        if (!dim_fb_i) r_err_fb <= 1'b1;
`endif
                        if (w_last_reg) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_reg <= r_reg + 4'd1;
                            r_dev <= '0;
                            if (r_delay == '0) begin
                                r_dim_trig <= 1'b1;
                                r_phase    <= '0;
                                r_state    <= ST_TRIG;
                            end else begin
                                r_state <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (w_tk_last) begin
                            r_dim_trig <= 1'b1;
                            r_phase    <= '0;
                            r_state    <= ST_TRIG;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign err_many_o     = r_err_many;
    assign err_fb_o       = r_err_fb;
    assign dim_count_o    = r_count;
    assign dim_reset_o    = r_dim_rst;
    assign dim_trig_o     = r_dim_trig;
    assign dim_clk_o      = r_dim_clk;
    assign mem.mem_we_o   = r_we;
    assign mem.mem_addr_o = r_addr;
    assign mem.mem_data_o = r_data;
endmodule
